// File: rtl/iot_event_arbiter_if.sv
// Bundle between the device-side producers / monitor and iot_event_arbiter.
//
// Handshake: an event on port i is transferred at a rising clk edge where
// ev_valid[i] and ev_ready[i] are both high. ev_valid[i] may be raised at any
// time, and ev_on_off[i] must be stable while ev_valid[i] is high. ev_ready[i]
// is high exactly when the one-entry slot of port i is empty. It does not
// depend on ev_valid.
//
// Signals
//   ev_valid   [N_DEV]  producer -> arbiter  per-port event request
//   ev_on_off  [N_DEV]  producer -> arbiter  1 = device on, 0 = device off
//   ev_ready   [N_DEV]  arbiter  -> producer per-port slot empty
//   count_in   [8]      monitor  -> arbiter  monitor counter_out
//   change              arbiter  -> monitor  one-cycle change pulse
//   on_off              arbiter  -> monitor  direction, valid with change
//   grant_id   [IDW]    arbiter  -> observer port of last issued/dropped event
//   drop_cnt   [8]      arbiter  -> observer saturating count of dropped events
//   busy                arbiter  -> observer FSM active or a slot pending
//   dbg_state  [2]      arbiter  -> observer FSM state (0 IDLE, 1 ISSUE, 2 SETTLE)
interface iot_event_arbiter_if #(
  parameter int N_DEV = 4,
  parameter int IDW   = 2
);
  logic [N_DEV-1:0] ev_valid;
  logic [N_DEV-1:0] ev_on_off;
  logic [N_DEV-1:0] ev_ready;
  logic [7:0]       count_in;
  logic             change;
  logic             on_off;
  logic [IDW-1:0]   grant_id;
  logic [7:0]       drop_cnt;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output ev_valid, ev_on_off, count_in,
    input  ev_ready, change, on_off, grant_id, drop_cnt, busy, dbg_state
  );

  modport slave (
    input  ev_valid, ev_on_off, count_in,
    output ev_ready, change, on_off, grant_id, drop_cnt, busy, dbg_state
  );
endinterface

// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter: buffers one on/off event per device port and serialises
// them round-robin onto the monitor's single change/on_off input. It drops
// events that would wrap the monitor's 8-bit count.
//
// Ports
//   clk  rising-edge clock shared with the monitor
//   rst  synchronous active-high reset
//   bus  iot_event_arbiter_if.slave (event handshake, monitor link, status)
//
// Each event takes three cycles: IDLE picks a pending port, ISSUE checks the
// count and pulses change, and SETTLE lets the monitor update. count_in is
// therefore never read while the monitor is still applying the previous change.
module iot_event_arbiter #(
  parameter int N_DEV = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  iot_event_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_DEV-1:0] pend, dir;
  logic [N_DEV-1:0] acc_mask, clr_mask;
  logic [IDW-1:0]   rr_ptr, sel, pick, sel_next_ptr;
  logic [IDW:0]     cand;
  logic             found, sel_dir, sat;
  logic             change_q, on_off_q;
  logic [IDW-1:0]   grant_q;
  logic [7:0]       drop_q;

  // Round-robin search: the first pending port at or after rr_ptr, wrapping
  // modulo N_DEV. cand has one extra bit so that rr_ptr+k cannot overflow
  // before the wrap is applied.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < N_DEV; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_DEV)) cand = cand - (IDW+1)'(N_DEV);
      if (!found && pend[cand[IDW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDW-1:0];
      end
    end
  end

  // The event would take the count below 0 or above 255.
  always_comb begin
    sel_dir      = dir[sel];
    sat          = sel_dir ? (bus.count_in == 8'hFF) : (bus.count_in == 8'h00);
    sel_next_ptr = (sel == IDW'(N_DEV - 1)) ? '0 : sel + 1'b1;
  end

  // A slot is cleared in ISSUE and can only be refilled while it is empty.
  // acc_mask and clr_mask therefore never share a bit.
  always_comb begin
    acc_mask = bus.ev_valid & ~pend;
    clr_mask = (state_q == ISSUE) ? (N_DEV'(1) << sel) : '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = ISSUE;
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend     <= '0;
      dir      <= '0;
      sel      <= '0;
      rr_ptr   <= '0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      grant_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      pend    <= (pend & ~clr_mask) | acc_mask;
      dir     <= (dir & ~acc_mask) | (bus.ev_on_off & acc_mask);
      case (state_q)
        IDLE: begin
          if (found) sel <= pick;
        end
        ISSUE: begin
          if (!sat) begin
            change_q <= 1'b1;
            on_off_q <= sel_dir;
          end else if (drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
          end
          grant_q <= sel;
          rr_ptr  <= sel_next_ptr;
        end
        SETTLE: begin
          change_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ev_ready  = rst ? '0 : ~pend;
  assign bus.change    = change_q;
  assign bus.on_off    = on_off_q;
  assign bus.grant_id  = grant_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.busy      = (state_q != IDLE) || (|pend);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Directed bench for iot_event_arbiter. A small monitor model drives count_in.
// Issued events are pushed to exp_q as {grant_id, on_off} when they are
// driven, and popped when change pulses.
module tb_iot_event_arbiter;
  localparam int N_DEV = 4;
  localparam int IDW   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iot_event_arbiter_if #(.N_DEV(N_DEV), .IDW(IDW)) bus();

  iot_event_arbiter #(.N_DEV(N_DEV), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // monitor model: counter_out follows change/on_off; force_* overrides it
  logic [7:0] mon_cnt;
  logic       mon_clr   = 1'b0;
  logic       force_en  = 1'b0;
  logic [7:0] force_val = 8'd0;
  assign bus.count_in = force_en ? force_val : mon_cnt;

  always @(posedge clk) begin
    if (rst || mon_clr) mon_cnt <= 8'd0;
    else if (bus.change) mon_cnt <= bus.on_off ? mon_cnt + 8'd1 : mon_cnt - 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  logic [IDW:0] exp_q[$];
  logic [IDW:0] exp_v;
  int pulse_cnt  = 0;
  int cyc        = 0;
  int last_pulse = -100;

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (bus.change) begin
        pulse_cnt++;
        check("pulse_gap", 32'(cyc - last_pulse >= 3), 32'd1);
        last_pulse = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_pulse: observed grant=%0d on_off=%0d expected no pulse",
                 bus.grant_id, bus.on_off);
        end else begin
          exp_v = exp_q.pop_front();
          check("issue", 32'({bus.grant_id, bus.on_off}), 32'(exp_v));
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [N_DEV-1:0] mask, input logic [N_DEV-1:0] dirs);
    bus.ev_valid  = mask;
    bus.ev_on_off = dirs;
    step();
    bus.ev_valid = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && (bus.busy || bus.change); i++) step();
    check(tag, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  int base;
  int acc;
  logic next_dir;

  initial begin
    bus.ev_valid  = '1;
    bus.ev_on_off = '0;
    rst = 1'b1;

    // reset held for 10 cycles with requests present
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_ready", 32'(bus.ev_ready), 32'd0);
      check("rst_change", 32'(bus.change), 32'd0);
      check("rst_drop", 32'(bus.drop_cnt), 32'd0);
    end
    rst = 1'b0;
    bus.ev_valid = '0;
    step();
    check("post_rst_ready", 32'(bus.ev_ready), 32'hF);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_grant", 32'(bus.grant_id), 32'd0);
    check("post_rst_on_off", 32'(bus.on_off), 32'd0);
    check("post_rst_state", 32'(bus.dbg_state), 32'd0);

    // round-robin: all four ports at once, order 0,1,2,3, pulses 3 apart
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd2, 1'b0});
    exp_q.push_back({2'd3, 1'b1});
    send(4'b1111, 4'b1011);
    for (int k = 0; k < 12; k++) begin
      check("rr_pulse", 32'(bus.change), 32'(k % 3 == 2));
      if (k < 11) step();
    end
    step();
    check("rr_count", 32'(bus.count_in), 32'd2);
    wait_idle("rr_idle", 20);

    // refill ports 1 and 3 with rr_ptr back at 0: order 1,3
    exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd3, 1'b0});
    send(4'b1010, 4'b0010);
    wait_idle("refill_idle", 20);
    check("refill_drained", 32'(exp_q.size()), 32'd0);
    check("refill_count", 32'(bus.count_in), 32'd2);

    // single event on port 2: change exactly in E+3
    exp_q.push_back({2'd2, 1'b1});
    send(4'b0100, 4'b0100);
    check("single_e1_change", 32'(bus.change), 32'd0);
    check("single_e1_ready", 32'(bus.ev_ready[2]), 32'd0);
    step();
    check("single_e2_change", 32'(bus.change), 32'd0);
    check("single_e2_state", 32'(bus.dbg_state), 32'd1);
    step();
    check("single_e3_change", 32'(bus.change), 32'd1);
    check("single_e3_on_off", 32'(bus.on_off), 32'd1);
    check("single_e3_grant", 32'(bus.grant_id), 32'd2);
    check("single_e3_ready", 32'(bus.ev_ready), 32'hF);
    step();
    check("single_e4_change", 32'(bus.change), 32'd0);
    check("single_e4_count", 32'(bus.count_in), 32'd3);

    // saturation drops
    base = pulse_cnt;
    force_en  = 1'b1;
    force_val = 8'd0;
    send(4'b0010, 4'b0000);
    wait_idle("sat_lo_idle", 20);
    check("sat_lo_drop", 32'(bus.drop_cnt), 32'd1);
    check("sat_lo_ready", 32'(bus.ev_ready), 32'hF);
    check("sat_lo_grant", 32'(bus.grant_id), 32'd1);
    force_val = 8'd255;
    send(4'b0010, 4'b0010);
    wait_idle("sat_hi_idle", 20);
    check("sat_hi_drop", 32'(bus.drop_cnt), 32'd2);
    check("sat_no_pulse", 32'(pulse_cnt - base), 32'd0);

    // opposite directions at the limits still issue
    exp_q.push_back({2'd0, 1'b0});
    send(4'b0001, 4'b0000);
    wait_idle("sat_hi_dec_idle", 20);
    force_val = 8'd0;
    exp_q.push_back({2'd3, 1'b1});
    send(4'b1000, 4'b1000);
    wait_idle("sat_lo_inc_idle", 20);
    check("sat_edge_pulses", 32'(pulse_cnt - base), 32'd2);
    check("sat_edge_drop", 32'(bus.drop_cnt), 32'd2);

    // drop counter saturates at 255
    for (int i = 0; i < 253; i++) begin
      send(4'b0001, 4'b0000);
      wait_idle("drop_loop_idle", 20);
    end
    check("drop_at_255", 32'(bus.drop_cnt), 32'd255);
    for (int i = 0; i < 2; i++) begin
      send(4'b0001, 4'b0000);
      wait_idle("drop_sat_idle", 20);
    end
    check("drop_stays_255", 32'(bus.drop_cnt), 32'd255);
    force_en = 1'b0;

    // back-to-back on port 0 with alternating direction
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
    base = pulse_cnt;
    acc = 0;
    next_dir = 1'b1;
    bus.ev_valid = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      if (bus.ev_ready[0]) begin
        bus.ev_on_off[0] = next_dir;
        exp_q.push_back({2'd0, next_dir});
        next_dir = !next_dir;
        acc++;
      end
      step();
      check("b2b_count_range", 32'(bus.count_in <= 8'd1), 32'd1);
    end
    bus.ev_valid = '0;
    wait_idle("b2b_idle", 20);
    check("b2b_accepted", 32'(acc), 32'd10);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_pulses", 32'(pulse_cnt - base), 32'(acc));
    check("b2b_final_count", 32'(bus.count_in), 32'(acc % 2));

    // reset while in ISSUE with three ports pending
    base = pulse_cnt;
    send(4'b0111, 4'b0111);
    step();
    check("mid_rst_state", 32'(bus.dbg_state), 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_change", 32'(bus.change), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_ready", 32'(bus.ev_ready), 32'd0);
    check("mid_rst_drop", 32'(bus.drop_cnt), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post_mid_rst_change", 32'(bus.change), 32'd0);
    end
    check("post_mid_rst_busy", 32'(bus.busy), 32'd0);
    check("post_mid_rst_ready", 32'(bus.ev_ready), 32'hF);
    check("post_mid_rst_pulses", 32'(pulse_cnt - base), 32'd0);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iot_event_arbiter.md
# iot_event_arbiter

Front-end scheduler for the active IoT devices monitor. Collects on/off events from `N_DEV` device ports, buffers one pending event per port, and serialises them round-robin onto the monitor's single `change`/`on_off` input. Saturation-checks each event against the monitor's `counter_out`, so the 8-bit count never wraps. Sits directly in front of `monitor`; shares its `clk` and `rst`.

## Interface
- `N_DEV`, default 4: number of device ports, 2..16.
- `IDW`, default 2: grant index width, equal to ceil(log2(`N_DEV`)).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ev_valid`  in  `N_DEV`  per-port event request.
- `ev_on_off`  in  `N_DEV`  per-port event type; 1 = device on (increment), 0 = device off (decrement).
- `ev_ready`  out  `N_DEV`  per-port slot empty; an event is accepted when `ev_valid[i]` and `ev_ready[i]` are both high at a clock edge.
- `count_in`  in  8  monitor `counter_out`.
- `change`  out  1  registered one-cycle pulse to monitor `change`.
- `on_off`  out  1  registered; direction for monitor, valid while `change`=1.
- `grant_id`  out  `IDW`  registered; port index of the last issued or dropped event.
- `drop_cnt`  out  8  registered; count of events rejected for saturation, saturates at 255.
- `busy`  out  1  high when the FSM is not in IDLE or any slot is pending.

## Operation
- Per port: one-entry slot holding `pend[i]` and `dir[i]`. `ev_ready[i]` = !`pend[i]`, and is forced low while `rst`=1.
- Accept: on an edge with `ev_valid[i] & ev_ready[i]`, set `pend[i]`=1 and `dir[i]`=`ev_on_off[i]`. Ports are accepted independently, and several may be accepted in the same cycle.
- Round-robin pointer `rr_ptr` (`IDW` bits). The search starts at `rr_ptr` and picks the first pending port in ascending order modulo `N_DEV`.
- FSM states:
  - **IDLE**: if any `pend` is set, latch the selected index in `sel` and go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE**:
    - Saturation check: if `dir[sel]`=1 and `count_in`=255, or `dir[sel]`=0 and `count_in`=0, the event is dropped. `change` stays 0, and `drop_cnt` increments unless it is already 255.
    - Otherwise the event is issued: `change`<=1 and `on_off`<=`dir[sel]`.
    - In both cases: clear `pend[sel]`, set `grant_id`<=`sel`, set `rr_ptr`<=(`sel`+1) mod `N_DEV`, and go to SETTLE.
  - **SETTLE**: `change`<=0. The monitor counter updates during this cycle. Go to IDLE.
- A slot cleared in ISSUE cannot be re-accepted in the same cycle, because `ev_ready` was low. It can be re-accepted from the next edge onward.
- The arbiter never issues while the monitor count is stale: `count_in` is only read in ISSUE, which is at least one cycle after the previous SETTLE.

## Timing
- Reset values: `change`=0, `on_off`=0, `grant_id`=0, `drop_cnt`=0, `busy`=0, FSM=IDLE, `rr_ptr`=0, all `pend`=0, `ev_ready`=0.
- `ev_ready` is all ones in the first cycle after `rst` is deasserted.
- Latency for an event accepted at edge E, with the FSM in IDLE and no competing ports:
  - pending in cycle E+1 (IDLE selects it);
  - ISSUE in E+2;
  - `change`=1 in E+3 (SETTLE);
  - monitor `counter_out` updated in E+4;
  - `ev_ready[i]` high again in E+3.
- Throughput: one event per 3 cycles (IDLE, ISSUE, SETTLE). `change` is never high in two consecutive cycles.
- Reset mid-operation: all pending events are discarded, and `change` is 0 in the cycle after the reset edge.

## Test plan
- Reset: hold `rst` for 10 cycles with `ev_valid`=all ones. Required: `ev_ready`=0, `change`=0, `drop_cnt`=0 throughout. After release, `ev_ready`=4'b1111.
- Single event: port 2 sends `on_off`=1 at edge E. Required: `change`=1 and `on_off`=1 exactly in cycle E+3, `grant_id`=2, `count_in` goes 0->1.
- Round-robin: all 4 ports send an event in the same cycle. Required: issue order 0,1,2,3, with `change` pulses exactly 3 cycles apart. Then refill ports 1 and 3 while `rr_ptr`=0. Required: order 1,3.
- Saturation: with `count_in`=0, send `on_off`=0 on port 1. Required: no `change` pulse, `drop_cnt`=1, `ev_ready[1]` high again. Drive `count_in`=255 and send `on_off`=1. Required: dropped, `drop_cnt`=2.
- Back-to-back: port 0 re-asserts `ev_valid` continuously with alternating `on_off`, for 30 cycles. Required: no lost events, the monitor count alternates 1,0,1,..., and the gap between `change` pulses is at least 3 cycles.
- Reset during ISSUE with 3 ports pending. Required: `change`=0 on the next cycle and all `pend` cleared. After reset, no pulse occurs without new requests.
